// File: rtl/rs_pkg.sv
// Shared constants and state encoding for the Reed-Solomon segment controller.
package rs_pkg;

  localparam int SEG_BYTES    = 172;
  localparam int PARITY_BYTES = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_DRAIN  = 2'd3
  } rs_state_e;

endpackage

// File: rtl/rs_segment_ctrl.sv
// Segment sequencer for the RS syndrome engine: accepts host segment requests,
// counts data and parity bytes, and issues start/endSegment/abort/segDone controls.
module rs_segment_ctrl #(
  parameter int  SEG_BYTES    = rs_pkg::SEG_BYTES,
  localparam int PARITY_BYTES = rs_pkg::PARITY_BYTES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       segReq,
  input  logic       segMode,
  input  logic       hostAbort,
  input  logic       dataRequest,
  output logic       segAck,
  output logic       start,
  output logic       encoding,
  output logic       endSegment,
  output logic       abort,
  output logic [7:0] byteCnt,
  output logic       busy,
  output logic       segDone,
  output logic       protErr,
  output logic [1:0] state_dbg
);

  import rs_pkg::rs_state_e;
  import rs_pkg::ST_IDLE;
  import rs_pkg::ST_DATA;
  import rs_pkg::ST_PARITY;
  import rs_pkg::ST_DRAIN;

  localparam logic [7:0] LAST_DATA = 8'(SEG_BYTES - 1);
  localparam logic [7:0] LAST_PAR  = 8'(PARITY_BYTES - 1);

  rs_state_e  state_q, state_d;
  logic [7:0] byte_cnt_q, byte_cnt_d;
  logic       encoding_q, encoding_d;
  logic       seg_done_q, seg_done_d;
  logic       prot_err_q, prot_err_d;

  logic       seg_ack_c, start_c, abort_c, end_seg_c, enc_mask_c;
  logic       last_data, last_par;
  logic [7:0] byte_cnt_inc;

  assign last_data    = (byte_cnt_q == LAST_DATA);
  assign last_par     = (byte_cnt_q == LAST_PAR);
  assign byte_cnt_inc = byte_cnt_q + 8'd1;

  // Handshake: segReq is a level request held by the host until segAck, which
  // pulses for exactly the cycle the request is taken; segMode is captured then.
  // segReq is only looked at in IDLE and in the last cycle of a segment.
  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    encoding_d = encoding_q;
    seg_done_d = 1'b0;
    prot_err_d = prot_err_q;
    seg_ack_c  = 1'b0;
    start_c    = 1'b0;
    abort_c    = 1'b0;
    end_seg_c  = 1'b0;
    enc_mask_c = 1'b0;

    if ((state_q == ST_DATA || state_q == ST_PARITY) && !dataRequest) begin
      prot_err_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (segReq) begin
          seg_ack_c  = 1'b1;
          start_c    = 1'b1;
          encoding_d = segMode;
          byte_cnt_d = 8'd0;
          state_d    = ST_DATA;
        end
      end

      ST_DATA: begin
        end_seg_c = last_data;
        if (hostAbort) begin
          // endSegment with encoding low drops the engine straight to standby.
          abort_c    = 1'b1;
          end_seg_c  = 1'b1;
          enc_mask_c = 1'b1;
          encoding_d = 1'b0;
          byte_cnt_d = 8'd0;
          state_d    = ST_IDLE;
        end else if (dataRequest) begin
          if (!last_data) begin
            byte_cnt_d = byte_cnt_inc;
          end else if (encoding_q) begin
            byte_cnt_d = 8'd0;
            state_d    = ST_PARITY;
          end else begin
            seg_done_d = 1'b1;
            start_c    = segReq;
            byte_cnt_d = 8'd0;
            if (segReq) begin
              seg_ack_c  = 1'b1;
              encoding_d = segMode;
            end else begin
              state_d = ST_IDLE;
            end
          end
        end
      end

      ST_PARITY: begin
        if (hostAbort) begin
          abort_c = 1'b1;
          if (last_par) begin
            byte_cnt_d = 8'd0;
            state_d    = ST_IDLE;
          end else begin
            byte_cnt_d = byte_cnt_inc;
            state_d    = ST_DRAIN;
          end
        end else if (!last_par) begin
          byte_cnt_d = byte_cnt_inc;
        end else begin
          seg_done_d = 1'b1;
          start_c    = segReq;
          byte_cnt_d = 8'd0;
          if (segReq) begin
            seg_ack_c  = 1'b1;
            encoding_d = segMode;
            state_d    = ST_DATA;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_DRAIN: begin
        // Engine still shifts out its parity bytes; let it finish without a start.
        if (last_par) begin
          byte_cnt_d = 8'd0;
          state_d    = ST_IDLE;
        end else begin
          byte_cnt_d = byte_cnt_inc;
        end
      end

      default: begin
        byte_cnt_d = 8'd0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      byte_cnt_q <= 8'd0;
      encoding_q <= 1'b0;
      seg_done_q <= 1'b0;
      prot_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      encoding_q <= encoding_d;
      seg_done_q <= seg_done_d;
      prot_err_q <= prot_err_d;
    end
  end

  // Same-cycle controls are gated by reset so they drop the moment reset asserts.
  assign segAck     = seg_ack_c & reset;
  assign start      = start_c & reset;
  assign abort      = abort_c & reset;
  assign endSegment = end_seg_c & reset;
  assign encoding   = encoding_q & ~enc_mask_c;
  assign byteCnt    = byte_cnt_q;
  assign busy       = (state_q != ST_IDLE);
  assign segDone    = seg_done_q;
  assign protErr    = prot_err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_rs_segment_ctrl.sv
// Self-checking bench for rs_segment_ctrl: directed scenarios plus a randomized
// segment stream checked against a segment-level timeline model.
module tb_rs_segment_ctrl;

  localparam int N     = 172;
  localparam int P     = 4;
  localparam int NSEG  = 10;
  localparam int MAXC  = 2500;

  logic       clk = 1'b0;
  logic       reset;
  logic       seg_req, seg_mode, host_abort, data_request;
  logic       seg_ack, start, encoding, end_segment, abort_o, busy, seg_done, prot_err;
  logic [7:0] byte_cnt;
  logic [1:0] state_dbg;

  int n_checks = 0;
  int n_pass   = 0;

  logic [15:0] exp_q[$];
  logic [14:0] e_vec[MAXC];
  logic        e_done[MAXC];
  logic        s_rq[MAXC];
  logic        s_md[MAXC];
  logic        s_ab[MAXC];

  always #5 clk = ~clk;

  rs_segment_ctrl #(.SEG_BYTES(N)) dut (
    .clk         (clk),
    .reset       (reset),
    .segReq      (seg_req),
    .segMode     (seg_mode),
    .hostAbort   (host_abort),
    .dataRequest (data_request),
    .segAck      (seg_ack),
    .start       (start),
    .encoding    (encoding),
    .endSegment  (end_segment),
    .abort       (abort_o),
    .byteCnt     (byte_cnt),
    .busy        (busy),
    .segDone     (seg_done),
    .protErr     (prot_err),
    .state_dbg   (state_dbg)
  );

  // Output vector layout: {segAck, start, encoding, endSegment, abort, busy, segDone, byteCnt}
  function automatic logic [14:0] obs();
    return {seg_ack, start, encoding, end_segment, abort_o, busy, seg_done, byte_cnt};
  endfunction

  // Drive one cycle's inputs after the falling edge, then settle before sampling.
  task automatic tick(input logic rq, input logic md, input logic ab, input logic dr);
    @(negedge clk);
    seg_req      = rq;
    seg_mode     = md;
    host_abort   = ab;
    data_request = dr;
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 2; i++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      n_checks++;
      if ({obs(), prot_err} !== 16'd0) $display("FAIL reset_hold got=%h exp=0000", {obs(), prot_err});
      else n_pass++;
    end
    seg_req = 1'b0;
    reset   = 1'b1;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    n_checks++;
    if ({obs(), prot_err} !== 16'd0) $display("FAIL reset_release got=%h exp=0000", {obs(), prot_err});
    else n_pass++;
  endtask

  task automatic test_decode_single();
    logic [14:0] exp;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    exp = {7'b1100000, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL dec_accept got=%h exp=%h", obs(), exp); else n_pass++;
    for (int k = 0; k < N; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      exp = {3'b000, (k == N - 1), 3'b010, 8'(k)};
      n_checks++;
      if (obs() !== exp) $display("FAIL dec_data k=%0d got=%h exp=%h", k, obs(), exp); else n_pass++;
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    exp = {7'b0000001, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL dec_done got=%h exp=%h", obs(), exp); else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    exp = 15'd0;
    n_checks++;
    if (obs() !== exp) $display("FAIL dec_idle got=%h exp=%h", obs(), exp); else n_pass++;
  endtask

  task automatic test_encode_single();
    logic [14:0] exp;
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    exp = {7'b1100000, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL enc_accept got=%h exp=%h", obs(), exp); else n_pass++;
    for (int k = 0; k < N; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      exp = {3'b001, (k == N - 1), 3'b010, 8'(k)};
      n_checks++;
      if (obs() !== exp) $display("FAIL enc_data k=%0d got=%h exp=%h", k, obs(), exp); else n_pass++;
    end
    for (int p = 0; p < P; p++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      exp = {7'b0010010, 8'(p)};
      n_checks++;
      if (obs() !== exp) $display("FAIL enc_parity p=%0d got=%h exp=%h", p, obs(), exp); else n_pass++;
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    exp = {7'b0010001, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL enc_done got=%h exp=%h", obs(), exp); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic [14:0] exp;
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    exp = {7'b1110000, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL b2b_accept got=%h exp=%h", obs(), exp); else n_pass++;
    for (int k = 0; k < N; k++) begin
      tick(1'b1, 1'b1, 1'b0, 1'b1);
      exp = (k == N - 1) ? {7'b1101010, 8'(k)} : {7'b0000010, 8'(k)};
      n_checks++;
      if (obs() !== exp) $display("FAIL b2b_dec k=%0d got=%h exp=%h", k, obs(), exp); else n_pass++;
    end
    for (int k = 0; k < N; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      exp = {3'b001, (k == N - 1), 2'b01, (k == 0), 8'(k)};
      n_checks++;
      if (obs() !== exp) $display("FAIL b2b_enc k=%0d got=%h exp=%h", k, obs(), exp); else n_pass++;
    end
    for (int p = 0; p < P; p++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      exp = {7'b0010010, 8'(p)};
      n_checks++;
      if (obs() !== exp) $display("FAIL b2b_parity p=%0d got=%h exp=%h", p, obs(), exp); else n_pass++;
    end
    tick(1'b0, 1'b0, 1'b0, 1'b0);
    exp = {7'b0010001, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL b2b_done got=%h exp=%h", obs(), exp); else n_pass++;
  endtask

  task automatic test_abort_data();
    logic [14:0] exp;
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    exp = {7'b1110000, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL abd_accept got=%h exp=%h", obs(), exp); else n_pass++;
    for (int k = 0; k < 50; k++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      exp = {7'b0010010, 8'(k)};
      n_checks++;
      if (obs() !== exp) $display("FAIL abd_data k=%0d got=%h exp=%h", k, obs(), exp); else n_pass++;
    end
    tick(1'b1, 1'b1, 1'b1, 1'b1);
    exp = {7'b0001110, 8'd50};
    n_checks++;
    if (obs() !== exp) $display("FAIL abd_abort got=%h exp=%h", obs(), exp); else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, 1'b0, 1'b1, 1'b1);
      exp = 15'd0;
      n_checks++;
      if (obs() !== exp) $display("FAIL abd_idle i=%0d got=%h exp=%h", i, obs(), exp); else n_pass++;
    end
  endtask

  task automatic test_abort_parity();
    logic [14:0] exp;
    tick(1'b1, 1'b1, 1'b0, 1'b1);
    exp = {7'b1100000, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL abp_accept got=%h exp=%h", obs(), exp); else n_pass++;
    for (int k = 0; k < N; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      exp = {3'b001, (k == N - 1), 3'b010, 8'(k)};
      n_checks++;
      if (obs() !== exp) $display("FAIL abp_data k=%0d got=%h exp=%h", k, obs(), exp); else n_pass++;
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {7'b0010010, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL abp_p0 got=%h exp=%h", obs(), exp); else n_pass++;
    tick(1'b0, 1'b1, 1'b1, 1'b1);
    exp = {7'b0010110, 8'd1};
    n_checks++;
    if (obs() !== exp) $display("FAIL abp_abort got=%h exp=%h", obs(), exp); else n_pass++;
    for (int p = 2; p < P; p++) begin
      tick(1'b1, 1'b0, 1'b0, 1'b1);
      exp = {7'b0010010, 8'(p)};
      n_checks++;
      if (obs() !== exp) $display("FAIL abp_drain p=%0d got=%h exp=%h", p, obs(), exp); else n_pass++;
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    exp = {7'b1110000, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL abp_reaccept got=%h exp=%h", obs(), exp); else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {7'b0000010, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL abp_newseg got=%h exp=%h", obs(), exp); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [14:0] exp;
    for (int k = 1; k <= 100; k++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      exp = {7'b0000010, 8'(k)};
      n_checks++;
      if (obs() !== exp) $display("FAIL rst_pre k=%0d got=%h exp=%h", k, obs(), exp); else n_pass++;
    end
    reset = 1'b0;
    #1;
    n_checks++;
    if ({obs(), prot_err} !== 16'd0) $display("FAIL rst_immediate got=%h exp=0000", {obs(), prot_err});
    else n_pass++;
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if ({obs(), prot_err} !== 16'd0) $display("FAIL rst_held got=%h exp=0000", {obs(), prot_err});
    else n_pass++;
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      n_checks++;
      if ({obs(), prot_err} !== 16'd0) $display("FAIL rst_after i=%0d got=%h exp=0000", i, {obs(), prot_err});
      else n_pass++;
    end
    tick(1'b1, 1'b0, 1'b0, 1'b1);
    exp = {7'b1100000, 8'd0};
    n_checks++;
    if (obs() !== exp) $display("FAIL rst_accept got=%h exp=%h", obs(), exp); else n_pass++;
    for (int k = 0; k < N; k++) begin
      if (k == 60) begin
        tick(1'b0, 1'b0, 1'b0, 1'b0);
        exp = {7'b0000010, 8'd60};
        n_checks++;
        if ({obs(), prot_err} !== {exp, 1'b0})
          $display("FAIL prot_stall got=%h exp=%h", {obs(), prot_err}, {exp, 1'b0});
        else n_pass++;
      end
      tick(1'b0, 1'b0, 1'b0, 1'b1);
      exp = {3'b000, (k == N - 1), 3'b010, 8'(k)};
      n_checks++;
      if ({obs(), prot_err} !== {exp, (k >= 60)})
        $display("FAIL prot_data k=%0d got=%h exp=%h", k, {obs(), prot_err}, {exp, (k >= 60)});
      else n_pass++;
    end
    tick(1'b0, 1'b0, 1'b0, 1'b1);
    exp = {7'b0000001, 8'd0};
    n_checks++;
    if ({obs(), prot_err} !== {exp, 1'b1})
      $display("FAIL prot_sticky got=%h exp=%h", {obs(), prot_err}, {exp, 1'b1});
    else n_pass++;
  endtask

  // Random segment stream: the expected trace is laid out from segment-level
  // timing (data bytes, parity bytes, abort point, chaining) before the run.
  task automatic test_random();
    int   n, len, abort_at;
    logic enc, mode, next_mode, chain, aborted;
    logic [14:0] exp;

    seg_req    = 1'b0;
    host_abort = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    reset = 1'b1;

    for (int c = 0; c < MAXC; c++) begin
      e_vec[c] = '0; e_done[c] = 1'b0; s_rq[c] = 1'b0; s_md[c] = 1'b0; s_ab[c] = 1'b0;
    end
    exp_q.delete();
    n = 0; enc = 1'b0; chain = 1'b0; next_mode = 1'b0;

    for (int seg = 0; seg < NSEG; seg++) begin
      if (!chain) begin
        repeat ($urandom_range(0, 2)) begin
          e_vec[n] = {2'b00, enc, 4'b0000, 8'd0};
          s_md[n]  = 1'($urandom_range(0, 1));
          s_ab[n]  = 1'($urandom_range(0, 1));
          n++;
        end
        mode     = 1'($urandom_range(0, 1));
        e_vec[n] = {2'b11, enc, 4'b0000, 8'd0};
        s_rq[n]  = 1'b1;
        s_md[n]  = mode;
        s_ab[n]  = 1'($urandom_range(0, 1));
        n++;
      end else begin
        mode = next_mode;
      end
      enc      = mode;
      len      = N + (mode ? P : 0);
      abort_at = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 1)) : -1;
      aborted  = 1'b0;
      chain    = 1'b0;
      for (int i = 0; i < len; i++) begin
        s_rq[n] = 1'($urandom_range(0, 1));
        s_md[n] = 1'($urandom_range(0, 1));
        if (i == abort_at) begin
          s_ab[n] = 1'b1;
          aborted = 1'b1;
          if (i < N) begin
            e_vec[n] = {7'b0001110, 8'(i)};
            enc = 1'b0;
            n++;
            break;
          end
          e_vec[n] = {2'b00, enc, 4'b0110, 8'(i - N)};
        end else if (i == len - 1 && !aborted) begin
          chain     = (seg < NSEG - 1) && ($urandom_range(0, 1) == 1);
          next_mode = 1'($urandom_range(0, 1));
          s_rq[n]   = chain;
          s_md[n]   = next_mode;
          e_vec[n]  = {chain, chain, enc, (i == N - 1), 3'b010, (i < N) ? 8'(i) : 8'(i - N)};
          e_done[n + 1] = 1'b1;
          exp_q.push_back(16'(n + 1));
        end else begin
          e_vec[n] = {2'b00, enc, (i == N - 1), 3'b010, (i < N) ? 8'(i) : 8'(i - N)};
        end
        n++;
      end
    end
    repeat (3) begin
      e_vec[n] = {2'b00, enc, 4'b0000, 8'd0};
      n++;
    end

    for (int c = 0; c < n; c++) begin
      tick(s_rq[c], s_md[c], s_ab[c], 1'b1);
      exp = e_vec[c] | {6'b000000, e_done[c], 8'd0};
      n_checks++;
      if (obs() !== exp) $display("FAIL rand_cycle c=%0d got=%h exp=%h", c, obs(), exp); else n_pass++;
      if (seg_done === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0 || exp_q[0] != 16'(c)) begin
          $display("FAIL rand_done_order c=%0d got=%0d exp=%0d", c, c, (exp_q.size() == 0) ? -1 : int'(exp_q[0]));
        end else begin
          n_pass++;
          void'(exp_q.pop_front());
        end
      end
    end
    n_checks++;
    if (exp_q.size() != 0 || prot_err !== 1'b0)
      $display("FAIL rand_end pending=%0d prot=%b exp_pending=0 exp_prot=0", exp_q.size(), prot_err);
    else n_pass++;
  endtask

  initial begin
    reset        = 1'b0;
    seg_req      = 1'b1;
    seg_mode     = 1'b1;
    host_abort   = 1'b0;
    data_request = 1'b1;
    test_reset();
    test_decode_single();
    test_encode_single();
    test_back_to_back();
    test_abort_data();
    test_abort_parity();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
